// File: rtl/matrix_storage_pkg.sv
// Shared slot-RAM layout constants, writer FSM state type and header packing helpers.
package matrix_storage_pkg;

  localparam int SLOT_BLOCK_SIZE = 1152;
  localparam int HEADER_WORDS    = 4;
  localparam int HDR_DIMS        = 0;
  localparam int HDR_NAME0       = 1;
  localparam int HDR_NAME1       = 2;
  localparam int HDR_CSUM        = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INVAL,
    ST_NAME0,
    ST_NAME1,
    ST_DATA,
    ST_CSUM,
    ST_COMMIT,
    ST_DONE,
    ST_ERR
  } slot_wr_state_t;

  function automatic int unsigned slot_base(input logic [2:0]  id,
                                            input int unsigned block_size = SLOT_BLOCK_SIZE);
    return 32'(id) * block_size;
  endfunction

  // First byte lands in the most significant lane.
  function automatic logic [31:0] pack_name4(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/matrix_slot_writer.sv
// Writes one matrix (header + row-major data) into its slot RAM, invalidating hdr0 first and committing it last.
// Optional build macro SLOT_WRITER_CHECKSUM_EN: when defined, hdr3 holds the wrapping sum of all elements; otherwise 0.
module matrix_slot_writer
  import matrix_storage_pkg::*;
#(
  parameter int BLOCK_SIZE = 1152,
  parameter int SLOTS      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_write_request,
  output logic                  o_write_ready,
  input  logic [2:0]            i_matrix_id,
  input  logic [7:0]            i_actual_rows,
  input  logic [7:0]            i_actual_cols,
  input  logic [7:0]            i_matrix_name [0:7],
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic                  i_data_valid,
  output logic                  o_writer_ready,
  output logic                  o_write_done,
  output logic                  o_write_error,
  output logic                  o_busy,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata
);

  // state  | meaning
  // IDLE   | wait for request    INVAL | hdr0 <= 0          NAME0/1 | name words
  // DATA   | stream elements     CSUM  | checksum word      COMMIT  | hdr0 <= dims
  // DONE   | done pulse          ERR   | reject pulse

  slot_wr_state_t r_state, w_next;

  logic [7:0]            r_rows, r_cols;
  logic [15:0]           r_total, r_cnt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [7:0]            r_name [0:7];
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] w_csum;

  logic [15:0] w_total_in;
  logic        w_reject, w_start, w_accept, w_last;

  assign w_total_in = 16'(i_actual_rows) * 16'(i_actual_cols);
  assign w_reject   = (i_actual_rows == 8'd0) || (i_actual_cols == 8'd0) ||
                      ({29'd0, i_matrix_id} >= 32'(SLOTS)) ||
                      ({16'd0, w_total_in} > 32'(BLOCK_SIZE - HEADER_WORDS));
  assign w_start    = (r_state == ST_IDLE) && i_write_request;

  assign o_writer_ready = (r_state == ST_DATA) && (r_cnt < r_total);
  assign w_accept       = o_writer_ready && i_data_valid;
  assign w_last         = (r_cnt == r_total - 16'd1);

  assign o_write_ready = (r_state == ST_IDLE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_write_done  = (r_state == ST_DONE);
  assign o_write_error = (r_state == ST_ERR);
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_write_request) w_next = w_reject ? ST_ERR : ST_INVAL;
      ST_INVAL:  w_next = ST_NAME0;
      ST_NAME0:  w_next = ST_NAME1;
      ST_NAME1:  w_next = ST_DATA;
      ST_DATA:   if (w_accept && w_last) w_next = ST_CSUM;
      ST_CSUM:   w_next = ST_COMMIT;
      ST_COMMIT: w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      ST_ERR:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rows  <= '0;
      r_cols  <= '0;
      r_total <= '0;
      r_cnt   <= '0;
      r_base  <= '0;
      r_name  <= '{default: '0};
    end else if (w_start) begin
      r_rows  <= i_actual_rows;
      r_cols  <= i_actual_cols;
      r_total <= w_total_in;
      r_cnt   <= '0;
      r_base  <= ADDR_WIDTH'(slot_base(i_matrix_id, BLOCK_SIZE));
      r_name  <= i_matrix_name;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

`ifdef SLOT_WRITER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_csum;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_csum <= '0;
    else if (w_start)  r_csum <= '0;
    else if (w_accept) r_csum <= r_csum + i_data_in;
  end
  assign w_csum = r_csum;
`else
  assign w_csum = '0;
`endif

  // Each state's RAM write is registered, so it appears on the bus one cycle after the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        ST_INVAL: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_base + ADDR_WIDTH'(HDR_DIMS);
          r_mem_wdata <= '0;
        end
        ST_NAME0: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_base + ADDR_WIDTH'(HDR_NAME0);
          r_mem_wdata <= DATA_WIDTH'(pack_name4(r_name[0], r_name[1], r_name[2], r_name[3]));
        end
        ST_NAME1: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_base + ADDR_WIDTH'(HDR_NAME1);
          r_mem_wdata <= DATA_WIDTH'(pack_name4(r_name[4], r_name[5], r_name[6], r_name[7]));
        end
        ST_DATA: if (w_accept) begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_base + ADDR_WIDTH'(HEADER_WORDS) + ADDR_WIDTH'(r_cnt);
          r_mem_wdata <= i_data_in;
        end
        ST_CSUM: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_base + ADDR_WIDTH'(HDR_CSUM);
          r_mem_wdata <= w_csum;
        end
        ST_COMMIT: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_base + ADDR_WIDTH'(HDR_DIMS);
          r_mem_wdata <= DATA_WIDTH'({16'd0, r_rows, r_cols});
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_slot_writer.sv
// Directed bench for matrix_slot_writer: RAM shadow model, header/data layout, timing and abort cases.
module tb_matrix_slot_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_write_request = 1'b0;
  logic        o_write_ready;
  logic [2:0]  i_matrix_id = '0;
  logic [7:0]  i_actual_rows = '0;
  logic [7:0]  i_actual_cols = '0;
  logic [7:0]  i_matrix_name [0:7];
  logic [31:0] i_data_in = '0;
  logic        i_data_valid = 1'b0;
  logic        o_writer_ready, o_write_done, o_write_error, o_busy, o_mem_we;
  logic [13:0] o_mem_addr;
  logic [31:0] o_mem_wdata;

  matrix_slot_writer dut (
    .clk(clk), .rst_n(rst_n),
    .i_write_request(i_write_request), .o_write_ready(o_write_ready),
    .i_matrix_id(i_matrix_id), .i_actual_rows(i_actual_rows), .i_actual_cols(i_actual_cols),
    .i_matrix_name(i_matrix_name), .i_data_in(i_data_in), .i_data_valid(i_data_valid),
    .o_writer_ready(o_writer_ready), .o_write_done(o_write_done), .o_write_error(o_write_error),
    .o_busy(o_busy), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nmis = 0;
  int          cyc = 0;
  int          last_edge = 0;
  logic [31:0] mem [0:16383];
  logic [45:0] wlog [$];

  always @(posedge clk) begin
    cyc++;
    if (o_mem_we) begin
      mem[o_mem_addr] = o_mem_wdata;
      wlog.push_back({o_mem_addr, o_mem_wdata});
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_name(input logic [63:0] n);
    for (int i = 0; i < 8; i++) i_matrix_name[i] = n[63-8*i -: 8];
  endtask

  task automatic request(input logic [2:0] id, input logic [7:0] rows, input logic [7:0] cols);
    i_matrix_id     = id;
    i_actual_rows   = rows;
    i_actual_cols   = cols;
    i_write_request = 1'b1;
    tick();
    i_write_request = 1'b0;
  endtask

  // Feeds n elements start, start+1, ...; optionally inserts an idle cycle after each.
  task automatic push(input int n, input logic [31:0] start, input bit gap);
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 20 && !o_writer_ready; b++) tick();
      if (!o_writer_ready) check_vec("writer_ready_timeout", o_writer_ready, 1'b1);
      i_data_in    = start + k;
      i_data_valid = 1'b1;
      tick();
      last_edge    = cyc;
      i_data_valid = 1'b0;
      if (gap) tick();
    end
  endtask

  task automatic wait_done(input string tag);
    for (int b = 0; b < 20 && !o_write_done; b++) tick();
    check_vec({tag, "_done"}, o_write_done, 1'b1);
    check_vec({tag, "_done_lat"}, cyc - last_edge, 2);
    tick();
  endtask

  logic [31:0] exp_csum;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    set_name(64'h0);
    tick();
    tick();
    check_vec("rst_write_ready", o_write_ready, 1'b1);
    check_vec("rst_busy", o_busy, 1'b0);
    check_vec("rst_mem_we", o_mem_we, 1'b0);
    check_vec("rst_writer_ready", o_writer_ready, 1'b0);
    check_vec("rst_flags", {o_write_done, o_write_error}, 2'b00);
    rst_n = 1'b1;
    tick();

    // 2x3 "A" into slot 1, data 1..6
    wlog.delete();
    set_name({8'h41, 56'h0});
    request(3'd1, 8'd2, 8'd3);
    check_vec("t1_busy", o_busy, 1'b1);
    check_vec("t1_wr_ready", o_write_ready, 1'b0);
    check_vec("t1_no_err", o_write_error, 1'b0);
    push(6, 32'd1, 1'b0);
    check_vec("t1_wrdy_drop", o_writer_ready, 1'b0);
    wait_done("t1");
`ifdef SLOT_WRITER_CHECKSUM_EN
    exp_csum = 32'd21;
`else
    exp_csum = 32'd0;
`endif
    check_vec("t1_nwrites", wlog.size(), 11);
    check_vec("t1_first_addr", 32'(wlog[0][45:32]), 32'd1152);
    check_vec("t1_first_data", wlog[0][31:0], 32'd0);
    check_vec("t1_last_addr", 32'(wlog[10][45:32]), 32'd1152);
    check_vec("t1_hdr0", mem[1152], 32'h0000_0203);
    check_vec("t1_hdr1", mem[1153], 32'h4100_0000);
    check_vec("t1_hdr2", mem[1154], 32'h0);
    check_vec("t1_csum", mem[1155], exp_csum);
    for (int k = 0; k < 6; k++) check_vec("t1_data", mem[1156+k], 32'(k + 1));
    check_vec("t1_idle", o_write_ready, 1'b1);

    // rejects: rows==0, then 34x34 (1156 > 1148)
    wlog.delete();
    request(3'd2, 8'd0, 8'd5);
    check_vec("e1_err", o_write_error, 1'b1);
    tick();
    check_vec("e1_err_clr", o_write_error, 1'b0);
    check_vec("e1_ready", o_write_ready, 1'b1);
    request(3'd1, 8'd34, 8'd34);
    check_vec("e2_err", o_write_error, 1'b1);
    check_vec("e2_busy", o_busy, 1'b1);
    tick();
    check_vec("e2_ready", o_write_ready, 1'b1);
    tick();
    check_vec("e_nwrites", wlog.size(), 0);
    check_vec("e_hdr0_kept", mem[1152], 32'h0000_0203);

    // 2x2 into slot 3, valid 1-0-1, competing request during DATA, extra valid after last
    wlog.delete();
    set_name(64'h5152_5354_5556_5758);
    request(3'd3, 8'd2, 8'd2);
    push(1, 32'h10, 1'b1);
    i_matrix_id = 3'd5; i_actual_rows = 8'd9; i_actual_cols = 8'd9;
    i_write_request = 1'b1;
    push(3, 32'h11, 1'b0);
    i_write_request = 1'b0;
    check_vec("t3_wrdy_drop", o_writer_ready, 1'b0);
    i_data_in = 32'hDEAD_BEEF;
    i_data_valid = 1'b1;
    tick();
    i_data_valid = 1'b0;
    wait_done("t3");
    check_vec("t3_nwrites", wlog.size(), 9);
    check_vec("t3_hdr0", mem[3456], 32'h0000_0202);
    check_vec("t3_name0", mem[3457], 32'h5152_5354);
    check_vec("t3_name1", mem[3458], 32'h5556_5758);
    for (int k = 0; k < 4; k++) check_vec("t3_data", mem[3460+k], 32'h10 + 32'(k));
    check_vec("t3_no_extra", mem[3464], 32'h0);
    check_vec("t3_slot5_hdr0", mem[5760], 32'h0);
    check_vec("t3_idle", o_write_ready, 1'b1);

    // 28x41 = 1148 fits exactly; aborted by reset
    request(3'd4, 8'd28, 8'd41);
    check_vec("b_no_err", o_write_error, 1'b0);
    check_vec("b_busy", o_busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // reset after 3 of 6 elements into slot 1
    request(3'd1, 8'd2, 8'd3);
    push(3, 32'd100, 1'b0);
    rst_n = 1'b0;
    #1;
    check_vec("r_write_ready", o_write_ready, 1'b1);
    check_vec("r_busy", o_busy, 1'b0);
    check_vec("r_mem_we", o_mem_we, 1'b0);
    check_vec("r_mem_addr", 32'(o_mem_addr), 32'd0);
    check_vec("r_writer_ready", o_writer_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check_vec("r_hdr0_empty", mem[1152], 32'h0);
    check_vec("r_ready_after", o_write_ready, 1'b1);

    // 1x1 into slot 7, max value
    wlog.delete();
    set_name(64'h4142_4344_4546_4748);
    request(3'd7, 8'd1, 8'd1);
    push(1, 32'hFFFF_FFFF, 1'b0);
    wait_done("t7");
`ifdef SLOT_WRITER_CHECKSUM_EN
    exp_csum = 32'hFFFF_FFFF;
`else
    exp_csum = 32'd0;
`endif
    check_vec("t7_nwrites", wlog.size(), 6);
    check_vec("t7_data", mem[8068], 32'hFFFF_FFFF);
    check_vec("t7_csum", mem[8067], exp_csum);
    check_vec("t7_hdr0", mem[8064], 32'h0000_0101);
    check_vec("t7_name0", mem[8065], 32'h4142_4344);
    check_vec("t7_name1", mem[8066], 32'h4546_4748);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
